// File: rtl/qc_ldpc_shift_sched.sv
// Shift scheduler for the QC-LDPC encoder rotate/accumulate datapath: walks the
// prototype table row by row and issues one rotate command per non-null circulant.
module qc_ldpc_shift_sched #(
   parameter int Z  = 81,
   parameter int MB = 4,
   parameter int KB = 20,
   parameter int SW = $clog2(Z),
   parameter int AW = $clog2(MB*KB),
   parameter int CW = $clog2(KB),
   parameter int RW = $clog2(MB)
) (
   input  logic          sysclk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   input  logic [SW:0]   rom_data,
   output logic          op_valid,
   input  logic          op_ready,
   output logic [CW-1:0] op_col,
   output logic [SW-1:0] op_shift,
   output logic          op_first,
   output logic          row_done,
   output logic [RW-1:0] row_idx,
   output logic          row_empty,
   output logic          done,
   output logic          busy,
   output logic          cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EVAL,
      S_ISSUE,
      S_ROW_END,
      S_DONE
   } state_t;

   localparam logic [CW-1:0] COL_LAST = CW'(KB - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(MB - 1);
   localparam logic [SW:0]   Z_LIM    = (SW+1)'(Z);

   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          first_q, first_d;
   logic [CW-1:0] op_col_q, op_col_d;
   logic [SW-1:0] op_shift_q, op_shift_d;
   logic          op_first_q, op_first_d;
   logic          cfg_err_q, cfg_err_d;

   logic          entry_null;
   logic          entry_bad;
   logic          col_last;

   assign entry_null = rom_data[SW];
   assign entry_bad  = !entry_null && ({1'b0, rom_data[SW-1:0]} >= Z_LIM);
   assign col_last   = (col_q == COL_LAST);

   // NOTE: reset is synchronous, and all state uses non-blocking assignment so every
   // register samples the pre-edge value of its neighbours.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         first_q    <= 1'b0;
         op_col_q   <= '0;
         op_shift_q <= '0;
         op_first_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         first_q    <= first_d;
         op_col_q   <= op_col_d;
         op_shift_q <= op_shift_d;
         op_first_q <= op_first_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // NOTE: every next-state value is defaulted to its current value first, so no
   // path through the case statement can infer a latch.
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      first_d    = first_q;
      op_col_d   = op_col_q;
      op_shift_d = op_shift_q;
      op_first_d = op_first_q;
      cfg_err_d  = cfg_err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               row_d     = '0;
               col_d     = '0;
               first_d   = 1'b1;
               cfg_err_d = 1'b0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: state_d = S_EVAL;
         S_EVAL: begin
            if (!entry_null && !entry_bad) begin
               op_col_d   = col_q;
               op_shift_d = rom_data[SW-1:0];
               op_first_d = first_q;
               state_d    = S_ISSUE;
            end else begin
               if (entry_bad) cfg_err_d = 1'b1;
               if (col_last) begin
                  state_d = S_ROW_END;
               end else begin
                  col_d   = col_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_ISSUE: begin
            if (op_ready) begin
               first_d = 1'b0;
               if (col_last) begin
                  state_d = S_ROW_END;
               end else begin
                  col_d   = col_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         S_ROW_END: begin
            if (row_q != ROW_LAST) begin
               row_d   = row_q + 1'b1;
               col_d   = '0;
               first_d = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort wins over a same-cycle handshake; cfg_err stays sticky across it.
      if (abort && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         row_d      = '0;
         col_d      = '0;
         first_d    = 1'b0;
         op_col_d   = '0;
         op_shift_d = '0;
         op_first_d = 1'b0;
      end
   end

   assign rom_en    = (state_q == S_FETCH);
   assign rom_addr  = AW'(row_q * KB) + AW'(col_q);
   assign op_valid  = (state_q == S_ISSUE);
   assign op_col    = op_col_q;
   assign op_shift  = op_shift_q;
   assign op_first  = op_first_q;
   assign row_done  = (state_q == S_ROW_END);
   assign row_idx   = row_q;
   assign row_empty = (state_q == S_ROW_END) && first_q;
   assign done      = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_qc_ldpc_shift_sched.sv
// Directed bench for qc_ldpc_shift_sched on a 2x3 prototype table with Z=81.
module tb_qc_ldpc_shift_sched;

   localparam int Z  = 81;
   localparam int MB = 2;
   localparam int KB = 3;
   localparam int SW = $clog2(Z);
   localparam int AW = $clog2(MB*KB);
   localparam int CW = $clog2(KB);
   localparam int RW = $clog2(MB);
   localparam logic [SW:0] NULL_E = 8'h80;

   typedef struct packed {
      logic [CW-1:0] col;
      logic [SW-1:0] shift;
      logic          first;
   } cmd_t;

   typedef struct packed {
      logic [RW-1:0] row;
      logic          empty;
   } rowev_t;

   logic          sysclk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          op_ready = 1'b0;
   logic [SW:0]   rom_data = '0;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic          op_valid;
   logic [CW-1:0] op_col;
   logic [SW-1:0] op_shift;
   logic          op_first;
   logic          row_done;
   logic [RW-1:0] row_idx;
   logic          row_empty;
   logic          done;
   logic          busy;
   logic          cfg_err;

   logic [SW:0]   rom_mem [8];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int c0 = 0;
   int done_n = 0;
   int done_cyc = 0;
   cmd_t   cmd_q[$];
   cmd_t   exp_q[$];
   rowev_t row_q[$];

   qc_ldpc_shift_sched #(.Z(Z), .MB(MB), .KB(KB)) dut (
      .sysclk(sysclk), .rst(rst), .start(start), .abort(abort),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .op_valid(op_valid), .op_ready(op_ready), .op_col(op_col),
      .op_shift(op_shift), .op_first(op_first), .row_done(row_done),
      .row_idx(row_idx), .row_empty(row_empty), .done(done),
      .busy(busy), .cfg_err(cfg_err)
   );

   always #5 sysclk = ~sysclk;

   always @(posedge sysclk) cyc <= cyc + 1;

   always @(posedge sysclk) if (rom_en) rom_data <= rom_mem[rom_addr];

   always @(negedge sysclk) begin
      if (!rst) begin
         if (op_valid && op_ready && !abort) cmd_q.push_back(cmd_t'{op_col, op_shift, op_first});
         if (row_done) row_q.push_back(rowev_t'{row_idx, row_empty});
         if (done) begin
            done_n   = done_n + 1;
            done_cyc = cyc - c0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic clear_logs();
      cmd_q.delete();
      exp_q.delete();
      row_q.delete();
      done_n = 0;
      done_cyc = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      c0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 200) begin
         tick();
         k++;
      end
      chk({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic cmp_cmds(input string tag);
      chk({tag, "_cmd_count"}, 32'(cmd_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < cmd_q.size(); i++)
         chk($sformatf("%s_cmd%0d", tag, i), 32'(cmd_q[i]), 32'(exp_q[i]));
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 8; i++) rom_mem[i] = NULL_E;
      for (int r = 0; r < MB; r++)
         for (int c = 0; c < KB; c++)
            rom_mem[r*KB + c] = (SW+1)'(r*10 + c);
   endtask

   task automatic exp_ramp();
      for (int r = 0; r < MB; r++)
         for (int c = 0; c < KB; c++)
            exp_q.push_back(cmd_t'{CW'(c), SW'(r*10 + c), (c == 0)});
   endtask

   initial begin
      load_ramp();

      // Reset state
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_op_valid", 32'(op_valid), 0);
      chk("rst_rom_en", 32'(rom_en), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      rst = 1'b0;
      tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_cfg_err", 32'(cfg_err), 0);

      // Full matrix, no stalls
      clear_logs();
      exp_ramp();
      op_ready = 1'b1;
      do_start();
      chk("t1_c1_rom_en", 32'(rom_en), 1);
      chk("t1_c1_rom_addr", 32'(rom_addr), 0);
      chk("t1_c1_busy", 32'(busy), 1);
      tick();
      chk("t1_c2_op_valid", 32'(op_valid), 0);
      tick();
      chk("t1_c3_op_valid", 32'(op_valid), 1);
      chk("t1_c3_op_first", 32'(op_first), 1);
      wait_done("t1");
      tick();
      chk("t1_busy_after", 32'(busy), 0);
      cmp_cmds("t1");
      chk("t1_rows", 32'(row_q.size()), 2);
      if (row_q.size() == 2) begin
         chk("t1_row0", 32'(row_q[0]), 32'(rowev_t'{1'b0, 1'b0}));
         chk("t1_row1", 32'(row_q[1]), 32'(rowev_t'{1'b1, 1'b0}));
      end
      chk("t1_done_n", 32'(done_n), 1);
      chk("t1_done_cyc", 32'(done_cyc), 21);

      // Sparse table: one command, second row empty
      clear_logs();
      for (int i = 0; i < 8; i++) rom_mem[i] = NULL_E;
      rom_mem[1] = 8'd5;
      exp_q.push_back(cmd_t'{2'd1, 7'd5, 1'b1});
      do_start();
      wait_done("t2");
      tick();
      cmp_cmds("t2");
      chk("t2_rows", 32'(row_q.size()), 2);
      if (row_q.size() == 2) begin
         chk("t2_row0", 32'(row_q[0]), 32'(rowev_t'{1'b0, 1'b0}));
         chk("t2_row1", 32'(row_q[1]), 32'(rowev_t'{1'b1, 1'b1}));
      end
      chk("t2_done_cyc", 32'(done_cyc), 16);

      // Back-pressure on the first command
      clear_logs();
      load_ramp();
      exp_ramp();
      op_ready = 1'b0;
      do_start();
      tick(); tick();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_hold%0d_valid", i), 32'(op_valid), 1);
         chk($sformatf("t3_hold%0d_col", i), 32'(op_col), 0);
         chk($sformatf("t3_hold%0d_shift", i), 32'(op_shift), 0);
         tick();
      end
      op_ready = 1'b1;
      wait_done("t3");
      tick();
      cmp_cmds("t3");
      chk("t3_done_cyc", 32'(done_cyc), 25);

      // Out-of-range shift at (0,1)
      clear_logs();
      rom_mem[1] = 8'd81;
      exp_q.push_back(cmd_t'{2'd0, 7'd0, 1'b1});
      exp_q.push_back(cmd_t'{2'd2, 7'd2, 1'b0});
      exp_q.push_back(cmd_t'{2'd0, 7'd10, 1'b1});
      exp_q.push_back(cmd_t'{2'd1, 7'd11, 1'b0});
      exp_q.push_back(cmd_t'{2'd2, 7'd12, 1'b0});
      do_start();
      chk("t4_c1_cfg_err", 32'(cfg_err), 0);
      wait_done("t4");
      chk("t4_cfg_err_at_done", 32'(cfg_err), 1);
      tick();
      chk("t4_cfg_err_idle", 32'(cfg_err), 1);
      cmp_cmds("t4");
      chk("t4_done_cyc", 32'(done_cyc), 20);
      clear_logs();
      rom_mem[1] = 8'd1;
      do_start();
      chk("t4_cfg_err_cleared", 32'(cfg_err), 0);
      wait_done("t4b");
      tick();
      chk("t4b_cfg_err", 32'(cfg_err), 0);

      // Abort colliding with a handshake
      clear_logs();
      do_start();
      tick(); tick();
      chk("t5_c3_op_valid", 32'(op_valid), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t5_busy", 32'(busy), 0);
      chk("t5_op_valid", 32'(op_valid), 0);
      chk("t5_op_first", 32'(op_first), 0);
      for (int i = 0; i < 6; i++) tick();
      chk("t5_no_cmd", 32'(cmd_q.size()), 0);
      chk("t5_no_done", 32'(done_n), 0);
      chk("t5_no_row", 32'(row_q.size()), 0);
      clear_logs();
      exp_ramp();
      do_start();
      tick(); tick();
      chk("t5r_op_valid", 32'(op_valid), 1);
      chk("t5r_op_first", 32'(op_first), 1);
      chk("t5r_op_col", 32'(op_col), 0);
      wait_done("t5r");
      tick();
      cmp_cmds("t5r");

      // start while busy is ignored
      clear_logs();
      exp_ramp();
      do_start();
      tick(); tick(); tick();
      start = 1'b1;
      tick(); tick();
      start = 1'b0;
      wait_done("t6");
      tick();
      cmp_cmds("t6");
      chk("t6_done_cyc", 32'(done_cyc), 21);
      chk("t6_done_n", 32'(done_n), 1);

      // Reset in EVAL
      do_start();
      tick();
      rst = 1'b1;
      tick();
      chk("t7_busy", 32'(busy), 0);
      chk("t7_rom_en", 32'(rom_en), 0);
      chk("t7_rom_addr", 32'(rom_addr), 0);
      chk("t7_op_valid", 32'(op_valid), 0);
      chk("t7_op_col", 32'(op_col), 0);
      chk("t7_op_shift", 32'(op_shift), 0);
      chk("t7_op_first", 32'(op_first), 0);
      chk("t7_row_done", 32'(row_done), 0);
      chk("t7_row_idx", 32'(row_idx), 0);
      chk("t7_row_empty", 32'(row_empty), 0);
      chk("t7_done", 32'(done), 0);
      chk("t7_cfg_err", 32'(cfg_err), 0);
      rst = 1'b0;
      tick(); tick();
      chk("t7_stays_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/qc_ldpc_shift_sched.md
# qc_ldpc_shift_sched

Sequencer for the QC-LDPC encoder rotate/accumulate datapath. Walks the base (prototype) matrix row by row over the information columns. For each entry it reads the shift value from the prototype-table ROM, skips null (all-zero) circulants, and issues one rotate-and-accumulate command per non-null circulant to the barrel rotator. It also marks the first command of each row, so the accumulator clears, and flags row and codeword completion.

## Interface
- `Z`, 81: circulant (lifting) size; rotator width.
- `MB`, 4: base-matrix rows (parity block rows).
- `KB`, 20: information block columns scanned per row.
- `SW`, `$clog2(Z)`: shift-amount width (derived).
- `AW`, `$clog2(MB*KB)`: ROM address width (derived).
- `sysclk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one codeword schedule; accepted only while `busy`=0.
- `abort` in 1: synchronous cancel of the current schedule.
- `rom_en` out 1: ROM read strobe.
- `rom_addr` out AW: row*KB + col.
- `rom_data` in SW+1: entry valid the cycle after `rom_en`. Bit SW=1 means null (-1 in the standard); bits SW-1:0 hold the shift.
- `op_valid` out 1: command valid.
- `op_ready` in 1: datapath accepts the command.
- `op_col` out `$clog2(KB)`: info column to feed the rotator.
- `op_shift` out SW: right-rotate amount.
- `op_first` out 1: first command of this row; accumulator loads instead of XOR-accumulating.
- `row_done` out 1: one-cycle pulse at the end of each row.
- `row_idx` out `$clog2(MB)`: row index; valid with `row_done`.
- `row_empty` out 1: row had no non-null entries; valid with `row_done`.
- `done` out 1: one-cycle pulse after the last row.
- `busy` out 1: high in every state except IDLE.
- `cfg_err` out 1: sticky. Set when a non-null entry has shift ≥ Z; cleared on accepted `start` or `rst`.

## Operation
- States: IDLE, FETCH, EVAL, ISSUE, ROW_END, DONE.
- IDLE: `start`=1 clears row/col counters, the first-flag and `cfg_err`, then goes to FETCH.
- FETCH (one cycle): `rom_en`=1, `rom_addr`=row*KB+col. Goes to EVAL.
- EVAL: samples `rom_data`.
  - Null entry: skip it.
  - Non-null entry with shift ≥ Z: skip it and set `cfg_err`.
  - Otherwise: latch `op_col`=col, `op_shift`=shift and `op_first`=first-flag; go to ISSUE.
  - On a skip: if col<KB-1, increment col and go to FETCH; else go to ROW_END.
- ISSUE: `op_valid`=1.
  - `op_col`, `op_shift` and `op_first` hold stable until `op_valid`&&`op_ready`.
  - On that handshake: clear the first-flag, then advance col as in EVAL.
- ROW_END (one cycle): `row_done`=1, `row_idx`=row, `row_empty`=first-flag (still set means nothing was issued).
  - If row<MB-1: row++, col=0, set the first-flag, go to FETCH.
  - Else go to DONE.
- DONE (one cycle): `done`=1, then go to IDLE.
- `abort`:
  - Outside IDLE: next state is IDLE, all outputs drop next cycle, and no `row_done` or `done` is generated.
  - Priority: `abort` beats the `op_ready` handshake in the same cycle. The command counts as not issued.
- `start` outside IDLE is ignored.
- `rst` has priority over everything. Reset values:
  - All outputs 0, state IDLE, counters 0.
  - `rom_addr`, `op_col`, `op_shift`, `row_idx` = 0.

## Timing
- `start` sampled at cycle 0 gives FETCH at 1, EVAL at 2, and the first `op_valid` at 3 (if entry (0,0) is non-null).
- Cost per entry with `op_ready` held high: non-null = 3 cycles; null = 2 cycles. ROW_END adds 1 per row; DONE adds 1.
- Full matrix with all N entries non-null and no stalls: 3·MB·KB + MB + 1 cycles from start to `done`. `busy` is high from cycle 1 to the DONE cycle inclusive.
- `op_valid` never deasserts without a handshake, except on `abort` or `rst`.
- `op_ready` may be high while `op_valid` is low; this has no effect.
- `row_done`/`done` are registered, one-cycle, and never coincident with `op_valid`.

## Test plan
- Z=81, MB=2, KB=3, all entries non-null with shift = row*10+col, `op_ready`=1 → six commands with shifts 0,1,2,10,11,12; `op_first` on the 1st and 4th; `row_done` rows 0,1 with `row_empty`=0; `done` at cycle 3·6+2+1=21 after start.
- Row 0 = {null, 5, null}, row 1 all null → one command (col 1, shift 5, first=1); row 1 `row_done` with `row_empty`=1; `done` asserted.
- Hold `op_ready`=0 for 4 cycles during the first ISSUE → `op_valid`/`op_col`/`op_shift` stable all 4 cycles; exactly one handshake; later commands unchanged.
- Entry shift=81 (≥Z) at (0,1) → entry skipped, `cfg_err` goes to 1 and stays set through `done`; a new `start` clears it.
- `abort` in the same cycle as an ISSUE handshake → IDLE next cycle, `busy`=0, no `done`; a new `start` replays from row 0 with `op_first`=1.
- `rst` asserted in EVAL, and `start` asserted while `busy`=1 → all outputs 0 the cycle after `rst`; the mid-run `start` produces no restart (command sequence unchanged).
